// File: rtl/tnn_csr_encoder.sv
// Dense ternary row to CSR stream encoder: emits row pointers and nonzero
// entries (column, sign) one item per cycle over a valid/ready stream.
module tnn_csr_encoder #(
   parameter int unsigned COL_CNT = 40,
   parameter int unsigned ROW_CNT = 10,
   parameter int unsigned COL_W   = $clog2(COL_CNT),
   parameter int unsigned CNT_W   = $clog2(ROW_CNT*COL_CNT+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               row_valid,
   output logic               row_ready,
   input  logic [COL_CNT-1:0] row_mask,
   input  logic [COL_CNT-1:0] row_sign,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_kind,
   output logic [CNT_W-1:0]   out_data,
   output logic               out_sign,
   output logic               done,
   output logic [CNT_W-1:0]   nnz_total
);

   localparam int unsigned ROW_W = $clog2(ROW_CNT+1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PTR,
      S_LOAD,
      S_EMIT,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [COL_CNT-1:0] mask_q, mask_d;
   logic [COL_CNT-1:0] rsign_q, rsign_d;
   logic [ROW_W-1:0]   rows_q, rows_d;
   logic [CNT_W-1:0]   nnz_q, nnz_d;
   logic               out_valid_q, out_valid_d;
   logic               out_kind_q, out_kind_d;
   logic [CNT_W-1:0]   out_data_q, out_data_d;
   logic               out_sign_q, out_sign_d;
   logic               row_ready_q, row_ready_d;
   logic               done_q, done_d;

   logic [COL_CNT-1:0] rem_mask;
   logic [COL_W-1:0]   rem_idx;
   logic [COL_W-1:0]   row_idx;

   // Index of the lowest set bit; 0 for an empty mask.
   function automatic logic [COL_W-1:0] lowest(input logic [COL_CNT-1:0] m);
      logic [COL_W-1:0] idx;
      idx = '0;
      for (int i = int'(COL_CNT) - 1; i >= 0; i--) begin
         if (m[i]) idx = COL_W'(i);
      end
      return idx;
   endfunction

   // Remaining mask after the presented (lowest) entry is accepted.
   assign rem_mask = mask_q & (mask_q - COL_CNT'(1));
   assign rem_idx  = lowest(rem_mask);
   assign row_idx  = lowest(row_mask);

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      rsign_d     = rsign_q;
      rows_d      = rows_q;
      nnz_d       = nnz_q;
      out_valid_d = out_valid_q;
      out_kind_d  = out_kind_q;
      out_data_d  = out_data_q;
      out_sign_d  = out_sign_q;
      row_ready_d = row_ready_q;
      done_d      = done_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_PTR;
               mask_d      = '0;
               rows_d      = '0;
               nnz_d       = '0;
               done_d      = 1'b0;
               out_valid_d = 1'b1;
               out_kind_d  = 1'b1;
               out_data_d  = '0;
               out_sign_d  = 1'b0;
            end
         end
         S_PTR: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_kind_d  = 1'b0;
               out_data_d  = '0;
               out_sign_d  = 1'b0;
               if (rows_q == ROW_W'(ROW_CNT)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d     = S_LOAD;
                  row_ready_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (row_valid) begin
               row_ready_d = 1'b0;
               mask_d      = row_mask;
               rsign_d     = row_sign;
               rows_d      = rows_q + ROW_W'(1);
               out_valid_d = 1'b1;
               if (row_mask == '0) begin
                  state_d    = S_PTR;
                  out_kind_d = 1'b1;
                  out_data_d = nnz_q;
                  out_sign_d = 1'b0;
               end else begin
                  state_d    = S_EMIT;
                  out_kind_d = 1'b0;
                  out_data_d = CNT_W'(row_idx);
                  out_sign_d = row_sign[row_idx];
               end
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               mask_d = rem_mask;
               nnz_d  = nnz_q + CNT_W'(1);
               if (rem_mask == '0) begin
                  state_d    = S_PTR;
                  out_kind_d = 1'b1;
                  out_data_d = nnz_q + CNT_W'(1);
                  out_sign_d = 1'b0;
               end else begin
                  out_kind_d = 1'b0;
                  out_data_d = CNT_W'(rem_idx);
                  out_sign_d = rsign_q[rem_idx];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         rsign_q     <= '0;
         rows_q      <= '0;
         nnz_q       <= '0;
         out_valid_q <= 1'b0;
         out_kind_q  <= 1'b0;
         out_data_q  <= '0;
         out_sign_q  <= 1'b0;
         row_ready_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         rsign_q     <= rsign_d;
         rows_q      <= rows_d;
         nnz_q       <= nnz_d;
         out_valid_q <= out_valid_d;
         out_kind_q  <= out_kind_d;
         out_data_q  <= out_data_d;
         out_sign_q  <= out_sign_d;
         row_ready_q <= row_ready_d;
         done_q      <= done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_kind  = out_kind_q;
   assign out_data  = out_data_q;
   assign out_sign  = out_sign_q;
   assign row_ready = row_ready_q;
   assign done      = done_q;
   assign nnz_total = nnz_q;

endmodule

// File: tb/tb_tnn_csr_encoder.sv
// Randomized bench for tnn_csr_encoder: the expected CSR stream is built
// directly from each dense matrix and compared item by item.
module tb_tnn_csr_encoder;

   localparam int unsigned COL_CNT = 40;
   localparam int unsigned ROW_CNT = 10;
   localparam int unsigned CNT_W   = 9;

   typedef struct {
      bit kind;
      bit sign;
      int data;
   } item_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               row_valid;
   logic               row_ready;
   logic [COL_CNT-1:0] row_mask;
   logic [COL_CNT-1:0] row_sign;
   logic               out_valid;
   logic               out_ready;
   logic               out_kind;
   logic [CNT_W-1:0]   out_data;
   logic               out_sign;
   logic               done;
   logic [CNT_W-1:0]   nnz_total;

   logic [COL_CNT-1:0] mask_m [ROW_CNT];
   logic [COL_CNT-1:0] sign_m [ROW_CNT];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tnn_csr_encoder #(.COL_CNT(COL_CNT), .ROW_CNT(ROW_CNT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_mask  (row_mask),
      .row_sign  (row_sign),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_kind  (out_kind),
      .out_data  (out_data),
      .out_sign  (out_sign),
      .done      (done),
      .nnz_total (nnz_total)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_case1();
      for (int r = 0; r < int'(ROW_CNT); r++) begin
         mask_m[r] = '0;
         sign_m[r] = '0;
      end
      mask_m[0][1] = 1'b1;
      mask_m[0][3] = 1'b1;
      sign_m[0][3] = 1'b1;
   endtask

   task automatic set_fill(input bit ones);
      for (int r = 0; r < int'(ROW_CNT); r++) begin
         mask_m[r] = ones ? '1 : '0;
         for (int c = 0; c < int'(COL_CNT); c++) sign_m[r][c] = ((c % 2) == 0);
      end
   endtask

   task automatic set_random();
      int dens;
      for (int r = 0; r < int'(ROW_CNT); r++) begin
         dens = int'($urandom_range(3));
         for (int c = 0; c < int'(COL_CNT); c++) begin
            mask_m[r][c] = (int'($urandom_range(3)) < dens);
            sign_m[r][c] = $urandom_range(1) == 1;
         end
      end
   endtask

   task automatic run_matrix(input int bp_pct, input int rv_pct, input bit rnd_start,
                             input bit stall3, input int abort_row);
      item_t q[$];
      item_t it;
      int    acc = 0;
      int    total = 0;
      int    ri = 0;
      int    cyc = 0;
      int    stall_left = 0;
      bit    stalled = 0;
      bit    prev_ent = 0;
      bit    prev_row = 0;
      bit    prev_nz = 0;

      // Reference stream: pointer, ascending nonzero columns, ..., closing pointer.
      for (int r = 0; r < int'(ROW_CNT); r++) begin
         it.kind = 1; it.sign = 0; it.data = total;
         q.push_back(it);
         for (int c = 0; c < int'(COL_CNT); c++) begin
            if (mask_m[r][c]) begin
               it.kind = 0; it.sign = sign_m[r][c]; it.data = c;
               q.push_back(it);
               total++;
            end
         end
      end
      it.kind = 1; it.sign = 0; it.data = total;
      q.push_back(it);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_lat_valid", 32'(out_valid), 1);
      check("start_lat_kind", 32'(out_kind), 1);
      check("start_nnz", 32'(nnz_total), 0);

      while (cyc < 5000) begin
         cyc++;
         if (done) break;
         if (prev_ent) check("no_bubble", 32'(out_valid), 1);
         if (prev_row) begin
            check("row_lat_valid", 32'(out_valid), 1);
            check("row_lat_kind", 32'(out_kind), 32'(!prev_nz));
         end
         prev_ent = 0;
         prev_row = 0;
         if (row_ready) check("ready_excl", 32'(out_valid), 0);

         if (abort_row >= 0 && ri > abort_row && out_valid && !out_kind) begin
            row_valid = 1'b0;
            rst = 1'b0;
            #1;
            check("rst_valid_now", 32'(out_valid), 0);
            check("rst_nnz_now", 32'(nnz_total), 0);
            @(posedge clk);
            #1;
            check("rst_valid", 32'(out_valid), 0);
            check("rst_nnz", 32'(nnz_total), 0);
            check("rst_ready", 32'(row_ready), 0);
            check("rst_done", 32'(done), 0);
            @(negedge clk);
            rst = 1'b1;
            out_ready = 1'b0;
            return;
         end

         if (stall3 && !stalled && out_valid && !out_kind && out_data == 3) begin
            stalled = 1;
            stall_left = 3;
         end
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            check("stall_valid", 32'(out_valid), 1);
            if (q.size() > 0) begin
               check("stall_data", 32'(out_data), q[0].data);
               check("stall_sign", 32'(out_sign), 32'(q[0].sign));
            end
            check("stall_nnz", 32'(nnz_total), acc);
         end else begin
            out_ready = (int'($urandom_range(99)) >= bp_pct);
         end

         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("extra_item", 1, 0);
            end else begin
               it = q.pop_front();
               check("kind", 32'(out_kind), 32'(it.kind));
               check("data", 32'(out_data), it.data);
               check("sign", 32'(out_sign), 32'(it.sign));
               check("nnz", 32'(nnz_total), acc);
               if (!it.kind) begin
                  acc++;
                  prev_ent = 1;
               end
            end
         end

         row_valid = (int'($urandom_range(99)) < rv_pct);
         row_mask  = (ri < int'(ROW_CNT)) ? mask_m[ri] : '0;
         row_sign  = (ri < int'(ROW_CNT)) ? sign_m[ri] : '0;
         if (row_ready && row_valid) begin
            prev_row = 1;
            prev_nz  = (row_mask != '0);
            ri++;
         end
         start = rnd_start ? ($urandom_range(3) == 0) : 1'b0;
         @(negedge clk);
      end

      start = 1'b0;
      out_ready = 1'b0;
      row_valid = 1'b0;
      check("no_timeout", 32'(cyc < 5000), 1);
      check("done", 32'(done), 1);
      check("nnz_final", 32'(nnz_total), total);
      check("stream_left", 32'(q.size()), 0);
      check("rows_used", 32'(ri), ROW_CNT);
      check("done_valid", 32'(out_valid), 0);
      check("done_ready", 32'(row_ready), 0);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      row_valid = 1'b0;
      row_mask = '0;
      row_sign = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_row_ready", 32'(row_ready), 0);
      check("rst_done", 32'(done), 0);
      check("rst_out_kind", 32'(out_kind), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_sign", 32'(out_sign), 0);
      check("rst_nnz_total", 32'(nnz_total), 0);
      rst = 1'b1;

      set_case1();
      run_matrix(0, 100, 0, 0, -1);
      set_fill(0);
      run_matrix(0, 100, 0, 0, -1);
      set_fill(1);
      run_matrix(0, 100, 0, 0, -1);
      set_case1();
      run_matrix(0, 100, 1, 1, -1);
      set_fill(1);
      run_matrix(20, 80, 0, 0, 4);
      set_case1();
      run_matrix(0, 100, 0, 0, -1);
      for (int k = 0; k < 6; k++) begin
         set_random();
         run_matrix(30, 60, 1, 0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
